// File: rtl/datapath_pkg.sv
// datapath_pkg: shared word type and responder FSM encoding for the scalar datapath.
// Rev 1.0
`default_nettype none

package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_t;

    localparam int unsigned CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/scalar_dmem_responder.sv
// scalar_dmem_responder: fixed-latency word memory answering scalar LS-unit loads/stores.
// Rev 1.0
`default_nettype none

module scalar_dmem_responder
    import datapath_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output logic  dhit,
    output word_t dmemload,
    output logic  addr_err
);

    localparam int unsigned     IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [32:0]     ADDR_LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);

    dmem_resp_state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             req_store;
    word_t            req_addr;
    word_t            req_data;
    word_t            mem [DEPTH_WORDS];

    logic             acc_store;
    word_t            acc_addr;
    word_t            acc_data;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             fire;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (dmemREN || dmemWEN) next_state = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, so use the live inputs.
    always_comb begin
        acc_store = (state == IDLE) ? dmemWEN   : req_store;
        acc_addr  = (state == IDLE) ? dmemaddr  : req_addr;
        acc_data  = (state == IDLE) ? dmemstore : req_data;
        acc_err   = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
        acc_idx   = acc_addr[2 +: IDX_W];
        fire      = (next_state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_store <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            dhit      <= 1'b0;
            dmemload  <= '0;
            addr_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && (dmemREN || dmemWEN)) begin
                req_store <= dmemWEN;
                req_addr  <= dmemaddr;
                req_data  <= dmemstore;
                cnt       <= WAIT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            dhit     <= fire;
            addr_err <= fire && acc_err;
            dmemload <= (fire && !acc_store && !acc_err) ? mem[acc_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (fire && acc_store && !acc_err) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scalar_dmem_responder.sv
// tb_scalar_dmem_responder: random and directed requests on LATENCY=2 and LATENCY=1 instances.
// Rev 1.0
`default_nettype none

module tb_scalar_dmem_responder;

    logic        clk;
    logic        rst;
    logic        ren   [2];
    logic        wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] sdata [2];
    logic        hit   [2];
    logic [31:0] load  [2];
    logic        aerr  [2];

    logic [31:0] mdl [2][256];
    int          checks;
    int          errors;

    scalar_dmem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_dut_l2 (
        .clk(clk), .rst(rst), .dmemREN(ren[0]), .dmemWEN(wen[0]),
        .dmemaddr(addr[0]), .dmemstore(sdata[0]),
        .dhit(hit[0]), .dmemload(load[0]), .addr_err(aerr[0])
    );

    scalar_dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut_l1 (
        .clk(clk), .rst(rst), .dmemREN(ren[1]), .dmemWEN(wen[1]),
        .dmemaddr(addr[1]), .dmemstore(sdata[1]),
        .dhit(hit[1]), .dmemload(load[1]), .addr_err(aerr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mdl[d][i] = 32'h0;
    endtask

    // One request end to end: the reference decides the response from address rules alone.
    task automatic run_req(input int d, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] dat, input bit hold);
        logic [31:0] exp_load;
        bit          exp_err;
        bit          seen;
        int          n;
        exp_err  = (a[1:0] != 2'b00) || (a >= 32'd1024);
        exp_load = 32'h0;
        if (!exp_err && !w) exp_load = mdl[d][a[9:2]];
        if (!exp_err && w)  mdl[d][a[9:2]] = dat;

        @(negedge clk);
        ren[d] = r; wen[d] = w; addr[d] = a; sdata[d] = dat;
        @(posedge clk);
        #1;
        if (!hold) begin
            ren[d] = 1'b0; wen[d] = 1'b0;
            addr[d] = $urandom; sdata[d] = $urandom;
        end
        n = 1; seen = 1'b0;
        while (!seen && n <= 20) begin
            @(negedge clk);
            if (hit[d]) seen = 1'b1;
            else begin
                check("idle_outputs", {load[d][31:1], load[d][0] | aerr[d]}, 32'h0);
                n++;
            end
        end
        check("dhit_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(n), 32'(lat(d)));
            check("dmemload", load[d], exp_load);
            check("addr_err", 32'(aerr[d]), 32'(exp_err));
        end
        ren[d] = 1'b0; wen[d] = 1'b0;
        @(negedge clk);
        check("dhit_pulse", 32'(hit[d]), 32'd0);
    endtask

    initial begin
        int          d;
        int          sel;
        logic [31:0] a;
        checks = 0; errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; sdata[i] = '0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_dhit", 32'(hit[i]), 32'd0);
            check("rst_load", load[i], 32'h0);
            check("rst_err",  32'(aerr[i]), 32'd0);
        end
        rst = 1'b0;

        run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

        // LATENCY=1 with the load held high: response every second cycle.
        @(negedge clk);
        ren[1] = 1'b1; addr[1] = 32'h20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("held_dhit", 32'(hit[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("held_load", load[1], 32'h0);
        end
        ren[1] = 1'b0;

        run_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        run_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
        run_req(0, 1'b0, 1'b1, 32'h11, 32'hFFFF_FFFF, 1'b0);
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        run_req(0, 1'b1, 1'b1, 32'h8, 32'h5, 1'b1);
        run_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        run_req(0, 1'b0, 1'b1, 32'h4, 32'h1234, 1'b0);
        run_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        run_req(1, 1'b1, 1'b1, 32'h3FC, 32'hA5A5_0001, 1'b0);
        run_req(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);

        // Reset while a store to 0xC is pending: nothing may complete or be written.
        @(negedge clk);
        wen[0] = 1'b1; addr[0] = 32'hC; sdata[0] = 32'h7777_7777;
        @(posedge clk);
        #1;
        wen[0] = 1'b0;
        rst = 1'b1;
        clear_model();
        repeat (3) begin
            @(negedge clk);
            check("rst_wait_dhit", 32'(hit[0]), 32'd0);
        end
        rst = 1'b0;
        run_req(0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            d   = $urandom_range(0, 1);
            sel = $urandom_range(0, 7);
            if (sel <= 5)      a = {22'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel == 6) a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else               a = 32'h400 + {$urandom_range(0, 4095), 2'b00};
            case ($urandom_range(0, 2))
                0:       run_req(d, 1'b1, 1'b0, a, $urandom, 1'($urandom));
                1:       run_req(d, 1'b0, 1'b1, a, $urandom, 1'($urandom));
                default: run_req(d, 1'b1, 1'b1, a, $urandom, 1'($urandom));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
